ekf_step_scheduler: RTL

Top-level sequencer for one EKF filter step. It generates the dt-period tick, starts the prediction stage, and starts the update stage when a measurement is pending. It also owns the single shared state-memory port, muxing it to whichever stage is active. It sits between the system interface (enable, measurement handshake, status) and the `ekf_predict` / update datapaths.

---
 rtl/ekf_params_pkg.sv | 26 ++
 rtl/ekf_mem_port_mux.sv | 49 ++++
 rtl/ekf_step_scheduler.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ekf_params_pkg.sv
// Shared EKF parameters, scheduler state encoding and memory-port select codes.
// Imported by the step scheduler and its memory-port mux.
package ekf_params_pkg;

  localparam int DATA_WIDTH         = 32;
  localparam int TOTAL_MEM_SIZE     = 256;
  localparam int AW                 = $clog2(TOTAL_MEM_SIZE);
  localparam int DEF_TICK_DIV       = 100000;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  typedef enum logic [2:0] {
    SCHED_IDLE        = 3'd0,
    SCHED_WAIT_TICK   = 3'd1,
    SCHED_RUN_PREDICT = 3'd2,
    SCHED_RUN_UPDATE  = 3'd3,
    SCHED_STEP_DONE   = 3'd4,
    SCHED_ERROR       = 3'd5
  } sched_state_t;

  typedef enum logic [1:0] {
    MEM_SEL_NONE = 2'd0,
    MEM_SEL_A    = 2'd1,
    MEM_SEL_B    = 2'd2
  } mem_sel_t;

endpackage

// File: rtl/ekf_mem_port_mux.sv
// Two-requester combinational state-memory port mux; the idle select parks
// the port with all outputs low so no stray write can occur.
module ekf_mem_port_mux
  import ekf_params_pkg::*;
(
  input  mem_sel_t              sel,
  input  logic [AW-1:0]         a_addr_rd,
  input  logic [AW-1:0]         a_addr_wr,
  input  logic [DATA_WIDTH-1:0] a_data_wr,
  input  logic                  a_we,
  input  logic [AW-1:0]         b_addr_rd,
  input  logic [AW-1:0]         b_addr_wr,
  input  logic [DATA_WIDTH-1:0] b_data_wr,
  input  logic                  b_we,
  output logic [AW-1:0]         mem_addr_rd,
  output logic [AW-1:0]         mem_addr_wr,
  output logic [DATA_WIDTH-1:0] mem_data_wr,
  output logic                  mem_we
);

  // Route the selected requester to the memory port
  always_comb begin
    mem_addr_rd = {AW{1'b0}};
    mem_addr_wr = {AW{1'b0}};
    mem_data_wr = {DATA_WIDTH{1'b0}};
    mem_we      = 1'b0;
    case (sel)
      MEM_SEL_A: begin
        mem_addr_rd = a_addr_rd;
        mem_addr_wr = a_addr_wr;
        mem_data_wr = a_data_wr;
        mem_we      = a_we;
      end
      MEM_SEL_B: begin
        mem_addr_rd = b_addr_rd;
        mem_addr_wr = b_addr_wr;
        mem_data_wr = b_data_wr;
        mem_we      = b_we;
      end
      default: begin
        mem_addr_rd = {AW{1'b0}};
        mem_addr_wr = {AW{1'b0}};
        mem_data_wr = {DATA_WIDTH{1'b0}};
        mem_we      = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ekf_step_scheduler.sv
// Sequencer for one EKF step: dt tick generation, predict/update start, stage
// timeout supervision, measurement handshake and state-memory port ownership.
module ekf_step_scheduler
  import ekf_params_pkg::*;
#(
  parameter int TICK_DIV       = DEF_TICK_DIV,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  meas_valid,
  output logic                  meas_ready,
  output logic                  predict_start,
  input  logic                  predict_done,
  output logic                  update_start,
  input  logic                  update_done,
  input  logic [AW-1:0]         pred_mem_addr_rd,
  input  logic [AW-1:0]         pred_mem_addr_wr,
  input  logic [DATA_WIDTH-1:0] pred_mem_data_wr,
  input  logic                  pred_mem_we,
  input  logic [AW-1:0]         upd_mem_addr_rd,
  input  logic [AW-1:0]         upd_mem_addr_wr,
  input  logic [DATA_WIDTH-1:0] upd_mem_data_wr,
  input  logic                  upd_mem_we,
  output logic [AW-1:0]         mem_addr_rd,
  output logic [AW-1:0]         mem_addr_wr,
  output logic [DATA_WIDTH-1:0] mem_data_wr,
  output logic                  mem_we,
  output logic                  busy,
  output logic                  step_done,
  output logic                  timeout_err,
  output logic [CNT_W-1:0]      step_cnt,
  output logic [CNT_W-1:0]      overrun_cnt
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int OW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [OW-1:0] TO_LAST   = OW'(TIMEOUT_CYCLES - 1);

  sched_state_t      state_r, next_state_s;
  logic [TW-1:0]     tick_cnt_r;
  logic [OW-1:0]     to_cnt_r;
  logic              tick_s, run_timeout_s, meas_pending_r, pending_next_s;
  logic              predict_start_r, update_start_r, step_done_r, busy_r;
  logic              timeout_err_r, meas_ready_r;
  logic [CNT_W-1:0]  step_cnt_r, overrun_cnt_r;
  mem_sel_t          mem_sel_s;

  assign tick_s        = enable && (tick_cnt_r == TICK_LAST);
  assign run_timeout_s = (to_cnt_r == TO_LAST);

  // Next-state logic; a done pulse takes priority over a coincident timeout
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      SCHED_IDLE: begin
        if (enable) next_state_s = SCHED_WAIT_TICK;
        else        next_state_s = SCHED_IDLE;
      end
      SCHED_WAIT_TICK: begin
        if (!enable)     next_state_s = SCHED_IDLE;
        else if (tick_s) next_state_s = SCHED_RUN_PREDICT;
        else             next_state_s = SCHED_WAIT_TICK;
      end
      SCHED_RUN_PREDICT: begin
        if (predict_done)       next_state_s = meas_pending_r ? SCHED_RUN_UPDATE : SCHED_STEP_DONE;
        else if (run_timeout_s) next_state_s = SCHED_ERROR;
        else                    next_state_s = SCHED_RUN_PREDICT;
      end
      SCHED_RUN_UPDATE: begin
        if (update_done)        next_state_s = SCHED_STEP_DONE;
        else if (run_timeout_s) next_state_s = SCHED_ERROR;
        else                    next_state_s = SCHED_RUN_UPDATE;
      end
      SCHED_STEP_DONE: begin
        if (enable) next_state_s = SCHED_WAIT_TICK;
        else        next_state_s = SCHED_IDLE;
      end
      SCHED_ERROR: begin
        if (!enable) next_state_s = SCHED_IDLE;
        else         next_state_s = SCHED_ERROR;
      end
      default: next_state_s = SCHED_IDLE;
    endcase
  end

  // A measurement is consumed by the update start that uses it
  always_comb begin
    pending_next_s = meas_pending_r;
    if (update_start_r)                    pending_next_s = 1'b0;
    else if (meas_valid && meas_ready_r)   pending_next_s = 1'b1;
    else                                   pending_next_s = meas_pending_r;
  end

  // State, period/timeout counters and handshake state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= SCHED_IDLE;
      tick_cnt_r     <= {TW{1'b0}};
      to_cnt_r       <= {OW{1'b0}};
      meas_pending_r <= 1'b0;
    end else begin
      state_r        <= next_state_s;
      meas_pending_r <= pending_next_s;
      if (!enable || tick_cnt_r == TICK_LAST) tick_cnt_r <= {TW{1'b0}};
      else                                    tick_cnt_r <= tick_cnt_r + TW'(1);
      if ((state_r == SCHED_RUN_PREDICT || state_r == SCHED_RUN_UPDATE) && next_state_s == state_r)
        to_cnt_r <= to_cnt_r + OW'(1);
      else
        to_cnt_r <= {OW{1'b0}};
    end
  end

  // Registered status outputs, derived from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      predict_start_r <= 1'b0;
      update_start_r  <= 1'b0;
      step_done_r     <= 1'b0;
      busy_r          <= 1'b0;
      timeout_err_r   <= 1'b0;
      meas_ready_r    <= 1'b0;
      step_cnt_r      <= {CNT_W{1'b0}};
      overrun_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      predict_start_r <= (next_state_s == SCHED_RUN_PREDICT) && (state_r != SCHED_RUN_PREDICT);
      update_start_r  <= (next_state_s == SCHED_RUN_UPDATE) && (state_r != SCHED_RUN_UPDATE);
      step_done_r     <= (next_state_s == SCHED_STEP_DONE);
      busy_r          <= (next_state_s == SCHED_RUN_PREDICT) || (next_state_s == SCHED_RUN_UPDATE) ||
                         (next_state_s == SCHED_STEP_DONE);
      timeout_err_r   <= (next_state_s == SCHED_ERROR);
      meas_ready_r    <= !pending_next_s;
      if (next_state_s == SCHED_STEP_DONE) step_cnt_r <= step_cnt_r + CNT_W'(1);
      else                                 step_cnt_r <= step_cnt_r;
      if (tick_s && state_r != SCHED_WAIT_TICK && overrun_cnt_r != {CNT_W{1'b1}})
        overrun_cnt_r <= overrun_cnt_r + CNT_W'(1);
      else
        overrun_cnt_r <= overrun_cnt_r;
    end
  end

  // Memory ownership follows the registered state only
  always_comb begin
    mem_sel_s = MEM_SEL_NONE;
    case (state_r)
      SCHED_RUN_PREDICT: mem_sel_s = MEM_SEL_A;
      SCHED_RUN_UPDATE:  mem_sel_s = MEM_SEL_B;
      default:           mem_sel_s = MEM_SEL_NONE;
    endcase
  end

  ekf_mem_port_mux u_mem_mux (
    .sel         (mem_sel_s),
    .a_addr_rd   (pred_mem_addr_rd),
    .a_addr_wr   (pred_mem_addr_wr),
    .a_data_wr   (pred_mem_data_wr),
    .a_we        (pred_mem_we),
    .b_addr_rd   (upd_mem_addr_rd),
    .b_addr_wr   (upd_mem_addr_wr),
    .b_data_wr   (upd_mem_data_wr),
    .b_we        (upd_mem_we),
    .mem_addr_rd (mem_addr_rd),
    .mem_addr_wr (mem_addr_wr),
    .mem_data_wr (mem_data_wr),
    .mem_we      (mem_we)
  );

  assign predict_start = predict_start_r;
  assign update_start  = update_start_r;
  assign step_done     = step_done_r;
  assign busy          = busy_r;
  assign timeout_err   = timeout_err_r;
  assign meas_ready    = meas_ready_r;
  assign step_cnt      = step_cnt_r;
  assign overrun_cnt   = overrun_cnt_r;

endmodule
